alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 52 +++++
 rtl/alu_arbiter_alu.sv | 50 +++++
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared opcode constants, flag bit positions and requester-id width for alu_arbiter.
package alu_arbiter_pkg;
  localparam int ID_W = 1;
  typedef logic [ID_W-1:0] id_t;

  localparam logic [4:0] ALUC_ADD  = 5'h01;
  localparam logic [4:0] ALUC_ADDU = 5'h02;
  localparam logic [4:0] ALUC_SUB  = 5'h03;
  localparam logic [4:0] ALUC_SUBU = 5'h04;
  localparam logic [4:0] ALUC_AND  = 5'h05;
  localparam logic [4:0] ALUC_OR   = 5'h06;
  localparam logic [4:0] ALUC_XOR  = 5'h07;
  localparam logic [4:0] ALUC_NOR  = 5'h08;
  localparam logic [4:0] ALUC_SLT  = 5'h09;
  localparam logic [4:0] ALUC_SLTU = 5'h0A;
  localparam logic [4:0] ALUC_SLL  = 5'h0B;
  localparam logic [4:0] ALUC_SRL  = 5'h0C;
  localparam logic [4:0] ALUC_SRA  = 5'h0D;
  localparam logic [4:0] ALUC_SLLV = 5'h0E;
  localparam logic [4:0] ALUC_SRLV = 5'h0F;
  localparam logic [4:0] ALUC_SRAV = 5'h10;
  localparam logic [4:0] ALUC_LUI  = 5'h11;
  localparam logic [4:0] ALUC_MUL  = 5'h12;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  aluc;
    id_t         id;
  } s1_t;

  function automatic logic aluc_legal(input logic [4:0] c);
    return (c >= ALUC_ADD) && (c <= ALUC_MUL);
  endfunction

  function automatic logic is_shift(input logic [4:0] c);
    return (c >= ALUC_SLL) && (c <= ALUC_SRAV);
  endfunction

  function automatic logic carry_en(input logic [4:0] c);
    return (c == ALUC_ADDU) || (c == ALUC_SUBU) || (c == ALUC_SLTU) || is_shift(c);
  endfunction

  function automatic logic ovf_en(input logic [4:0] c);
    return (c == ALUC_ADD) || (c == ALUC_SUB);
  endfunction
endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 32-bit ALU; raw flags only, masking is done by the caller.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  aluc,
  output logic [31:0] r,
  output logic        zero,
  output logic        carry,
  output logic        negative,
  output logic        overflow
);
  // Shift amount comes from a[4:0], data from b; V and non-V forms differ only in operand source upstream.
  always_comb begin
    r        = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (aluc)
      ALUC_ADD: begin
        r        = a + b;
        overflow = (a[31] == b[31]) && (r[31] != a[31]);
      end
      ALUC_ADDU: {carry, r} = {1'b0, a} + {1'b0, b};
      ALUC_SUB: begin
        r        = a - b;
        overflow = (a[31] != b[31]) && (r[31] != a[31]);
      end
      ALUC_SUBU: {carry, r} = {1'b0, a} - {1'b0, b};
      ALUC_AND:  r = a & b;
      ALUC_OR:   r = a | b;
      ALUC_XOR:  r = a ^ b;
      ALUC_NOR:  r = ~(a | b);
      ALUC_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      ALUC_SLTU: begin
        r     = {31'd0, a < b};
        carry = a < b;
      end
      ALUC_SLL, ALUC_SLLV: {carry, r} = {1'b0, b} << a[4:0];
      ALUC_SRL, ALUC_SRLV: {r, carry} = {b, 1'b0} >> a[4:0];
      ALUC_SRA, ALUC_SRAV: {r, carry} = $signed({b, 1'b0}) >>> a[4:0];
      ALUC_LUI:  r = {b[15:0], 16'h0000};
      ALUC_MUL:  r = a * b;
      default:   r = '0;
    endcase
  end

  assign zero     = (r == '0);
  assign negative = r[31];
endmodule

// File: rtl/alu_arbiter.sv
// Two-requester ALU front end: arbiter -> S1 operand regs -> ALU -> S2 result regs.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_aluc,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_aluc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_r,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);
  s1_t  s1_q, s1_d;
  logic s1_valid;
  logic s2_valid, s2_fire, s2_free, s1_free;
  logic pref0, pref1, gnt0, gnt1;

  assign s2_valid = rsp0_valid | rsp1_valid;
  assign s2_fire  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
  assign s2_free  = !s2_valid || s2_fire;
  assign s1_free  = !s1_valid || s2_free;

`ifdef ALU_ARB_RR_EN
  logic rr_ptr;
  assign pref0 = !rr_ptr;
  assign pref1 = rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rr_ptr <= 1'b0;
    else if (gnt0 && !rr_ptr)  rr_ptr <= 1'b1;
    else if (gnt1 && rr_ptr)   rr_ptr <= 1'b0;
  end
`else
  assign pref0 = 1'b1;
  assign pref1 = 1'b0;
`endif

  // Each ready looks only at the other side's valid, so no requester sees a loop through itself.
  assign req0_ready = rst_n && s1_free && (pref0 || !req1_valid);
  assign req1_ready = rst_n && s1_free && (pref1 || !req0_valid);
  assign gnt0 = req0_valid && req0_ready;
  assign gnt1 = req1_valid && req1_ready;

  always_comb begin
    s1_d = '{a: req0_a, b: req0_b, aluc: req0_aluc, id: id_t'(0)};
    if (gnt1) s1_d = '{a: req1_a, b: req1_b, aluc: req1_aluc, id: id_t'(1)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_free) begin
      s1_valid <= gnt0 || gnt1;
      if (gnt0 || gnt1) s1_q <= s1_d;
    end
  end

  logic [31:0] alu_r;
  logic        alu_z, alu_c, alu_n, alu_v;

  alu_arbiter_alu u_alu (
    .a        (s1_q.a),
    .b        (s1_q.b),
    .aluc     (s1_q.aluc),
    .r        (alu_r),
    .zero     (alu_z),
    .carry    (alu_c),
    .negative (alu_n),
    .overflow (alu_v)
  );

  logic [31:0] res_r;
  logic [3:0]  res_f;
  logic        res_err, shift_nocarry;

  // A zero low nibble on a shift suppresses carry regardless of the raw ALU value.
  assign shift_nocarry = is_shift(s1_q.aluc) && (s1_q.a[3:0] == 4'h0);

  always_comb begin
    res_err        = !aluc_legal(s1_q.aluc);
    res_r          = alu_r;
    res_f          = '0;
    res_f[FLAG_Z]  = alu_z;
    res_f[FLAG_C]  = alu_c && carry_en(s1_q.aluc) && !shift_nocarry;
    res_f[FLAG_N]  = alu_n;
    res_f[FLAG_V]  = alu_v && ovf_en(s1_q.aluc);
    if (res_err) begin
      res_r         = '0;
      res_f         = '0;
      res_f[FLAG_Z] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_r      <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else if (s2_free) begin
      rsp0_valid <= s1_valid && (s1_q.id == id_t'(0));
      rsp1_valid <= s1_valid && (s1_q.id == id_t'(1));
      if (s1_valid) begin
        rsp_r     <= res_r;
        rsp_flags <= res_f;
        rsp_err   <= res_err;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, contention, backpressure, reset and random traffic.
module tb_alu_arbiter;
  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_aluc, req1_aluc;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_r;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_r(rsp_r), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        id;
    logic [31:0] r;
    logic [3:0]  f;
    logic        e;
  } exp_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, r;
    logic [3:0]  f;
    logic        e;
  } vec_t;

  int   total = 0, bad = 0;
  bit   sb_on = 1'b0;
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference behaviour: bit-serial shifts, wide adds, flags {z,c,n,v}.
  function automatic exp_t model(input logic id, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        x;
    logic [31:0] v;
    logic [63:0] w;
    logic        c, o;
    int          n;
    x.id = id; x.e = 1'b0; c = 1'b0; o = 1'b0; v = b; n = int'(a[4:0]);
    case (op)
      5'h01: begin v = a + b; o = (a[31] == b[31]) && (v[31] != a[31]); end
      5'h02: begin w = {32'd0, a} + {32'd0, b}; v = w[31:0]; c = w[32]; end
      5'h03: begin v = a - b; o = (a[31] != b[31]) && (v[31] != a[31]); end
      5'h04: begin v = a - b; c = (a < b); end
      5'h05: v = a & b;
      5'h06: v = a | b;
      5'h07: v = a ^ b;
      5'h08: v = ~(a | b);
      5'h09: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'h0A: begin v = (a < b) ? 32'd1 : 32'd0; c = (a < b); end
      5'h0B, 5'h0E: for (int i = 0; i < n; i++) begin c = v[31]; v = {v[30:0], 1'b0}; end
      5'h0C, 5'h0F: for (int i = 0; i < n; i++) begin c = v[0]; v = {1'b0, v[31:1]}; end
      5'h0D, 5'h10: for (int i = 0; i < n; i++) begin c = v[0]; v = {v[31], v[31:1]}; end
      5'h11: v = {b[15:0], 16'h0};
      5'h12: v = a * b;
      default: x.e = 1'b1;
    endcase
    if (op >= 5'h0B && op <= 5'h10 && a[3:0] == 4'h0) c = 1'b0;
    if (x.e) begin x.r = '0; x.f = 4'b1000; end
    else begin x.r = v; x.f = {v == 32'd0, c, v[31], o}; end
    return x;
  endfunction

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb_on) begin
      if (req0_valid && req0_ready) sbq.push_back(model(1'b0, req0_aluc, req0_a, req0_b));
      if (req1_valid && req1_ready) sbq.push_back(model(1'b1, req1_aluc, req1_a, req1_b));
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        if (sbq.size() == 0) chk("sb_spurious_rsp", 32'd1, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("sb_id", {31'd0, rsp1_valid}, {31'd0, e.id});
          chk("sb_r", rsp_r, e.r);
          chk("sb_flags", {28'd0, rsp_flags}, {28'd0, e.f});
          chk("sb_err", {31'd0, rsp_err}, {31'd0, e.e});
        end
      end
    end
  end

  function automatic logic [4:0] rnd_op();
    return 5'($urandom_range(0, 20));
  endfunction

  task automatic do_reset();
    sb_on = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sbq.delete();
    sb_on = 1'b1;
  endtask

  vec_t tbl[26];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic  a0, a1;
    int    k, cyc, cnt;
    exp_t  first;
    logic [4:0]  bp_op[4];
    logic [31:0] bp_a[4], bp_b[4];

    tbl[0]  = '{5'h02, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1100, 1'b0};
    tbl[1]  = '{5'h01, 32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b0011, 1'b0};
    tbl[2]  = '{5'h05, 32'hF0,       32'h3C,       32'h30,       4'b0000, 1'b0};
    tbl[3]  = '{5'h1F, 32'h12345678, 32'h9,        32'h0,        4'b1000, 1'b1};
    tbl[4]  = '{5'h00, 32'h1,        32'h1,        32'h0,        4'b1000, 1'b1};
    tbl[5]  = '{5'h13, 32'h5,        32'h5,        32'h0,        4'b1000, 1'b1};
    tbl[6]  = '{5'h04, 32'h1,        32'h2,        32'hFFFFFFFF, 4'b0110, 1'b0};
    tbl[7]  = '{5'h03, 32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b0001, 1'b0};
    tbl[8]  = '{5'h0A, 32'h1,        32'h2,        32'h1,        4'b0100, 1'b0};
    tbl[9]  = '{5'h09, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b0000, 1'b0};
    tbl[10] = '{5'h0B, 32'h4,        32'hF0000001, 32'h10,       4'b0100, 1'b0};
    tbl[11] = '{5'h0C, 32'h0,        32'h80000000, 32'h80000000, 4'b0010, 1'b0};
    tbl[12] = '{5'h0D, 32'h1,        32'h80000001, 32'hC0000000, 4'b0110, 1'b0};
    tbl[13] = '{5'h0B, 32'h10,       32'h00018000, 32'h80000000, 4'b0010, 1'b0};
    tbl[14] = '{5'h07, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 4'b0000, 1'b0};
    tbl[15] = '{5'h08, 32'h0,        32'h0,        32'hFFFFFFFF, 4'b0010, 1'b0};
    tbl[16] = '{5'h06, 32'h0,        32'h0,        32'h0,        4'b1000, 1'b0};
    tbl[17] = '{5'h01, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b1000, 1'b0};
    tbl[18] = '{5'h11, 32'h0,        32'h1234,     32'h12340000, 4'b0000, 1'b0};
    tbl[19] = '{5'h12, 32'h3,        32'h5,        32'hF,        4'b0000, 1'b0};
    tbl[20] = '{5'h0F, 32'h8,        32'h0000FF00, 32'hFF,       4'b0000, 1'b0};
    tbl[21] = '{5'h0E, 32'h1,        32'h80000000, 32'h0,        4'b1100, 1'b0};
    tbl[22] = '{5'h10, 32'h4,        32'h8000000F, 32'hF8000000, 4'b0110, 1'b0};
    tbl[23] = '{5'h04, 32'h5,        32'h5,        32'h0,        4'b1000, 1'b0};
    tbl[24] = '{5'h01, 32'h80000000, 32'h80000000, 32'h0,        4'b1001, 1'b0};
    tbl[25] = '{5'h0A, 32'h5,        32'h3,        32'h0,        4'b1000, 1'b0};

    // Reset state, with both requesters asserting valid throughout.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_a = 32'hFFFFFFFF; req0_b = 32'h1; req0_aluc = 5'h02;
    req1_valid = 1'b1; req1_a = 32'h7FFFFFFF; req1_b = 32'h1; req1_aluc = 5'h01;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #12;
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_r", rsp_r, 32'd0);
    chk("rst_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    req1_valid = 1'b0;
    sb_on = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_after_rst", {31'd0, req0_ready}, 32'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Vector table through requester 0 with a fixed 2-cycle latency.
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_aluc = tbl[i].op; req0_a = tbl[i].a; req0_b = tbl[i].b;
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), {31'd0, req0_ready}, 32'd1);
      @(posedge clk); #1 req0_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_lat1", i), {31'd0, rsp0_valid}, 32'd0);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), {31'd0, rsp0_valid}, 32'd1);
      chk($sformatf("vec%0d_r", i), rsp_r, tbl[i].r);
      chk($sformatf("vec%0d_flags", i), {28'd0, rsp_flags}, {28'd0, tbl[i].f});
      chk($sformatf("vec%0d_err", i), {31'd0, rsp_err}, {31'd0, tbl[i].e});
    end

    // Contention: both requesters valid for 4 cycles from a fresh reset.
    do_reset();
    req0_valid = 1'b1; req0_aluc = rnd_op(); req0_a = $urandom; req0_b = $urandom;
    req1_valid = 1'b1; req1_aluc = rnd_op(); req1_a = $urandom; req1_b = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("cont%0d_ready0", i), {31'd0, req0_ready}, RR ? ((i % 2 == 0) ? 32'd1 : 32'd0) : 32'd1);
      chk($sformatf("cont%0d_ready1", i), {31'd0, req1_ready}, RR ? ((i % 2 == 1) ? 32'd1 : 32'd0) : 32'd0);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0) begin req0_aluc = rnd_op(); req0_a = $urandom; req0_b = $urandom; end
      if (a1) begin req1_aluc = rnd_op(); req1_a = $urandom; req1_b = $urandom; end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(posedge clk);
    chk("cont_drain", sbq.size(), 32'd0);

    // Backpressure: response 0 stalled for 3 cycles under back-to-back requests.
    do_reset();
    bp_op[0] = 5'h02; bp_a[0] = 32'h11;       bp_b[0] = 32'h22;
    bp_op[1] = 5'h07; bp_a[1] = 32'hFF00FF00; bp_b[1] = 32'h0F0F0F0F;
    bp_op[2] = 5'h0C; bp_a[2] = 32'h3;        bp_b[2] = 32'h8000000F;
    bp_op[3] = 5'h1F; bp_a[3] = 32'h1;        bp_b[3] = 32'h2;
    first = model(1'b0, bp_op[0], bp_a[0], bp_b[0]);
    rsp0_ready = 1'b0;
    k = 0; cyc = 0;
    req0_valid = 1'b1; req0_aluc = bp_op[0]; req0_a = bp_a[0]; req0_b = bp_b[0];
    while ((k < 4 || sbq.size() != 0) && cyc < 40) begin
      @(negedge clk);
      if (cyc < 2) chk($sformatf("bp%0d_ready_open", cyc), {31'd0, req0_ready}, 32'd1);
      if (cyc >= 2 && cyc <= 4) begin
        chk($sformatf("bp%0d_ready_stall", cyc), {31'd0, req0_ready}, 32'd0);
        chk($sformatf("bp%0d_rsp_held", cyc), {31'd0, rsp0_valid}, 32'd1);
        chk($sformatf("bp%0d_r_stable", cyc), rsp_r, first.r);
      end
      a0 = req0_valid && req0_ready;
      @(posedge clk); #1;
      if (a0) begin
        k++;
        if (k < 4) begin req0_aluc = bp_op[k]; req0_a = bp_a[k]; req0_b = bp_b[k]; end
        else req0_valid = 1'b0;
      end
      if (cyc == 4) rsp0_ready = 1'b1;
      cyc++;
    end
    chk("bp_all_accepted", k, 32'd4);
    chk("bp_no_loss", sbq.size(), 32'd0);

    // Reset while S1 and S2 are both occupied.
    do_reset();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_aluc = 5'h02; req0_a = 32'h1; req0_b = 32'h2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_s2_full", {31'd0, rsp0_valid}, 32'd1);
    chk("mid_s1_full", {31'd0, req0_ready}, 32'd0);
    #2 rst_n = 1'b0;
    sb_on = 1'b0;
    #1;
    chk("mid_rsp0_clear", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rsp1_clear", {31'd0, rsp1_valid}, 32'd0);
    chk("mid_ready_low", {31'd0, req0_ready}, 32'd0);
    chk("mid_r_clear", rsp_r, 32'd0);
    chk("mid_flags_clear", {28'd0, rsp_flags}, 32'd0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sbq.delete();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    sb_on = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) cnt++;
    end
    chk("mid_no_rsp_after_release", cnt, 32'd0);

    // Random traffic on both requesters with random response backpressure.
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk); #1;
      if (a0 || !req0_valid) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_aluc = rnd_op(); req0_a = $urandom; req0_b = $urandom;
      end
      if (a1 || !req1_valid) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_aluc = rnd_op(); req1_a = $urandom; req1_b = $urandom;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (8) @(posedge clk);
    chk("rand_drain", sbq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
